// File: rtl/omr_sheet_scanner.sv
// OMR sheet scanner: accepts NUM_Q sensed bubble rows and keeps only clean one-hot marks.
// It assembles them into the grader's answer word and counts blank and multi-marked rows.
module omr_sheet_scanner #(
    parameter int NUM_Q   = 10,
    parameter int NUM_OPT = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     row_valid,
    input  logic [NUM_OPT-1:0]       row_bubbles,
    output logic                     row_ready,
    output logic [NUM_Q*NUM_OPT-1:0] answers,
    output logic                     answers_valid,
    input  logic                     answers_ready,
    output logic [3:0]               blank_count,
    output logic [3:0]               multi_count,
    output logic [3:0]               row_count,
    output logic                     busy,
    output logic                     sheet_error
);

    localparam int               TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [3:0]       LAST_ROW = 4'(NUM_Q - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t                        state;
    logic [NUM_Q-1:0][NUM_OPT-1:0] sheet;
    logic [TMR_W-1:0]              idle_cycles;
    logic [3:0]                    slot;
    logic                          one_mark;
    logic                          no_mark;

    // Row 0 lands in the top slot so question 1 is the most significant nibble.
    assign answers  = sheet;
    assign slot     = LAST_ROW - row_count;
    assign one_mark = $onehot(row_bubbles);
    assign no_mark  = (row_bubbles == '0);

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch reads the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the answer bank is plain flops, not a RAM, so it can be cleared here.
            state         <= IDLE;
            sheet         <= '0;
            blank_count   <= '0;
            multi_count   <= '0;
            row_count     <= '0;
            idle_cycles   <= '0;
            row_ready     <= 1'b0;
            answers_valid <= 1'b0;
            busy          <= 1'b0;
            sheet_error   <= 1'b0;
        end else begin
            sheet_error <= 1'b0;
            if (start && state != HOLD) begin
                // Restart discards any row offered in the same cycle.
                state       <= SCAN;
                sheet       <= '0;
                blank_count <= '0;
                multi_count <= '0;
                row_count   <= '0;
                idle_cycles <= '0;
                row_ready   <= 1'b1;
                busy        <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: ;
                    SCAN: begin
                        if (row_valid) begin
                            sheet[slot] <= one_mark ? row_bubbles : '0;
                            blank_count <= blank_count + 4'(no_mark);
                            multi_count <= multi_count + 4'(!one_mark && !no_mark);
                            row_count   <= row_count + 4'd1;
                            idle_cycles <= '0;
                            if (row_count == LAST_ROW) begin
                                state         <= HOLD;
                                row_ready     <= 1'b0;
                                answers_valid <= 1'b1;
                            end
                        end else if (idle_cycles == TMR_LAST) begin
                            // Abandoned sheet: drop partial results so nothing stale is graded.
                            state       <= IDLE;
                            sheet       <= '0;
                            blank_count <= '0;
                            multi_count <= '0;
                            row_count   <= '0;
                            idle_cycles <= '0;
                            row_ready   <= 1'b0;
                            busy        <= 1'b0;
                            sheet_error <= 1'b1;
                        end else begin
                            idle_cycles <= idle_cycles + TMR_W'(1);
                        end
                    end
                    HOLD: begin
                        if (answers_ready) begin
                            state         <= IDLE;
                            answers_valid <= 1'b0;
                            busy          <= 1'b0;
                        end
                    end
                    default: begin
                        state         <= IDLE;
                        row_ready     <= 1'b0;
                        answers_valid <= 1'b0;
                        busy          <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_omr_sheet_scanner.sv
// Self-checking bench for omr_sheet_scanner: directed scenarios with random rows and gaps.
// The bench's reference model packs the answer word by shifting and counts marks per row.
module tb_omr_sheet_scanner;

    localparam int NUM_Q   = 10;
    localparam int NUM_OPT = 4;
    localparam int TIMEOUT = 255;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic                     row_valid;
    logic [NUM_OPT-1:0]       row_bubbles;
    logic                     row_ready;
    logic [NUM_Q*NUM_OPT-1:0] answers;
    logic                     answers_valid;
    logic                     answers_ready;
    logic [3:0]               blank_count;
    logic [3:0]               multi_count;
    logic [3:0]               row_count;
    logic                     busy;
    logic                     sheet_error;

    omr_sheet_scanner #(.NUM_Q(NUM_Q), .NUM_OPT(NUM_OPT), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .row_valid    (row_valid),
        .row_bubbles  (row_bubbles),
        .row_ready    (row_ready),
        .answers      (answers),
        .answers_valid(answers_valid),
        .answers_ready(answers_ready),
        .blank_count  (blank_count),
        .multi_count  (multi_count),
        .row_count    (row_count),
        .busy         (busy),
        .sheet_error  (sheet_error)
    );

    always #5 clk = ~clk;

    int                       checks = 0;
    int                       errors = 0;
    logic [NUM_OPT-1:0]       rows [NUM_Q];
    logic [NUM_Q*NUM_OPT-1:0] exp_ans;
    int                       exp_blank;
    int                       exp_multi;
    logic [NUM_Q*NUM_OPT-1:0] saved_ans;
    bit                       err_early;
    bit                       saw_valid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int marks(input logic [NUM_OPT-1:0] v);
        int n = 0;
        for (int b = 0; b < NUM_OPT; b++) n += int'(v[b]);
        return n;
    endfunction

    function automatic logic [NUM_OPT-1:0] rand_row();
        logic [NUM_OPT-1:0] v;
        case ($urandom_range(0, 5))
            0: v = '0;
            1: begin
                v = NUM_OPT'($urandom_range(0, 15));
                while (marks(v) < 2) v = NUM_OPT'($urandom_range(0, 15));
            end
            default: v = NUM_OPT'(1 << $urandom_range(0, NUM_OPT - 1));
        endcase
        return v;
    endfunction

    // Reference: question 1 is shifted in first so it ends up most significant.
    task automatic model();
        exp_ans   = '0;
        exp_blank = 0;
        exp_multi = 0;
        for (int k = 0; k < NUM_Q; k++) begin
            int m = marks(rows[k]);
            exp_ans = (exp_ans << NUM_OPT) | ((m == 1) ? rows[k] : '0);
            if (m == 0) exp_blank++;
            if (m > 1) exp_multi++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input int first, input int last, input bit gaps);
        for (int k = first; k <= last; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    row_valid   = 1'b0;
                    row_bubbles = NUM_OPT'($urandom_range(0, 15));
                    step();
                end
            end
            row_valid   = 1'b1;
            row_bubbles = rows[k];
            step();
        end
        row_valid = 1'b0;
    endtask

    task automatic random_rows();
        for (int k = 0; k < NUM_Q; k++) rows[k] = rand_row();
    endtask

    task automatic check_hold(input string tag);
        model();
        check({tag, "_valid"}, answers_valid, 1);
        check({tag, "_answers"}, answers, exp_ans);
        check({tag, "_blank"}, blank_count, exp_blank);
        check({tag, "_multi"}, multi_count, exp_multi);
        check({tag, "_rows"}, row_count, NUM_Q);
        check({tag, "_ready"}, row_ready, 0);
        check({tag, "_busy"}, busy, 1);
    endtask

    task automatic release_sheet(input string tag);
        answers_ready = 1'b1;
        step();
        answers_ready = 1'b0;
        check({tag, "_rel_valid"}, answers_valid, 0);
        check({tag, "_rel_busy"}, busy, 0);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        row_valid     = 1'b0;
        row_bubbles   = '0;
        answers_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_valid", answers_valid, 0);
        check("rst_ready", row_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_err", sheet_error, 0);
        check("rst_answers", answers, 0);
        check("rst_counts", {blank_count, multi_count, row_count}, 0);

        // Nominal sheet, back-to-back rows
        rows = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0001,
                 4'b0010, 4'b0001, 4'b1000, 4'b1000, 4'b1000};
        pulse_start();
        check("start_busy", busy, 1);
        check("start_ready", row_ready, 1);
        check("start_rows", row_count, 0);
        feed(0, NUM_Q - 2, 1'b0);
        check("nom_valid_early", answers_valid, 0);
        check("nom_rows9", row_count, NUM_Q - 1);
        feed(NUM_Q - 1, NUM_Q - 1, 1'b0);
        check_hold("nom");
        check("nom_golden", answers, 40'h1224121888);

        // Backpressure in HOLD with row_valid toggling
        saved_ans = answers;
        for (int i = 0; i < 5; i++) begin
            row_valid   = ~row_valid;
            row_bubbles = NUM_OPT'($urandom_range(0, 15));
            step();
            check("bp_valid", answers_valid, 1);
            check("bp_answers", answers, saved_ans);
            check("bp_ready", row_ready, 0);
        end
        row_valid = 1'b0;
        release_sheet("bp");
        step();
        check("idle_answers_kept", answers, saved_ans);
        check("idle_rows_kept", row_count, NUM_Q);

        // Blank and multi-marked rows
        rows[3] = 4'b0000;
        rows[5] = 4'b0110;
        pulse_start();
        feed(0, NUM_Q - 1, 1'b1);
        check_hold("bad");
        check("bad_nib3", answers[(NUM_Q - 3) * NUM_OPT - 1 -: NUM_OPT], 0);
        check("bad_nib5", answers[(NUM_Q - 5) * NUM_OPT - 1 -: NUM_OPT], 0);
        check("bad_blank1", blank_count, 1);
        check("bad_multi1", multi_count, 1);
        release_sheet("bad");

        // Random sheets; start in HOLD must be ignored
        for (int s = 0; s < 4; s++) begin
            random_rows();
            pulse_start();
            feed(0, NUM_Q - 1, 1'b1);
            check_hold("rnd");
            saved_ans = answers;
            pulse_start();
            check("hold_start_valid", answers_valid, 1);
            check("hold_start_rows", row_count, NUM_Q);
            check("hold_start_answers", answers, saved_ans);
            release_sheet("rnd");
        end

        // Restart mid-sheet; the row offered with start is discarded
        random_rows();
        pulse_start();
        feed(0, 5, 1'b0);
        check("rs_rows6", row_count, 6);
        start       = 1'b1;
        row_valid   = 1'b1;
        row_bubbles = 4'b0001;
        step();
        start     = 1'b0;
        row_valid = 1'b0;
        check("rs_rows0", row_count, 0);
        check("rs_answers0", answers, 0);
        check("rs_counts0", {blank_count, multi_count}, 0);
        check("rs_busy", busy, 1);
        random_rows();
        feed(0, NUM_Q - 1, 1'b1);
        check_hold("rs");
        release_sheet("rs");

        // Timeout after 4 rows
        random_rows();
        rows[0] = 4'b0000;
        rows[1] = 4'b0011;
        pulse_start();
        feed(0, 3, 1'b0);
        check("to_rows4", row_count, 4);
        err_early = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            step();
            if (sheet_error) err_early = 1'b1;
            if (answers_valid) saw_valid = 1'b1;
        end
        check("to_no_early_err", err_early, 0);
        check("to_busy_before", busy, 1);
        step();
        check("to_err_pulse", sheet_error, 1);
        check("to_busy", busy, 0);
        check("to_rows", row_count, 0);
        check("to_answers", answers, 0);
        check("to_counts", {blank_count, multi_count}, 0);
        check("to_ready", row_ready, 0);
        check("to_never_valid", saw_valid | answers_valid, 0);
        step();
        check("to_err_one_cycle", sheet_error, 0);

        // Reset wins over start/row_valid/answers_ready while in HOLD
        random_rows();
        pulse_start();
        feed(0, NUM_Q - 1, 1'b1);
        check_hold("rh");
        reset         = 1'b1;
        start         = 1'b1;
        answers_ready = 1'b1;
        row_valid     = 1'b1;
        step();
        reset         = 1'b0;
        start         = 1'b0;
        answers_ready = 1'b0;
        row_valid     = 1'b0;
        check("rh_valid", answers_valid, 0);
        check("rh_ready", row_ready, 0);
        check("rh_busy", busy, 0);
        check("rh_err", sheet_error, 0);
        check("rh_answers", answers, 0);
        check("rh_counts", {blank_count, multi_count, row_count}, 0);
        step();
        check("rh_idle", {busy, row_ready}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
